// File: rtl/sms4_tau_serial.sv
// sms4_tau_serial: byte-serial SMS4 non-linear transform tau.
//
// A single S-box datapath (input map -> inv8 -> output map) is time-shared
// across the four bytes of a 32-bit word, MSB byte first. The result is held
// in HOLD until the consumer handshakes it.
//
// Optional build macro:
//   SBOX_PIPE_EN  - registers the inv8 output (8-bit data + valid + index)
//                   and adds a DRAIN state; latency 5, period 7 instead of
//                   latency 4, period 6.
//
// Field choice: inv8 works in GF(2^8) with the SMS4 S-box polynomial
// x^8+x^7+x^6+x^5+x^4+x^2+1 in polynomial basis. In that basis the
// isomorphism into the inversion field is the identity, so both the input
// and the output map reduce to the SMS4 affine step y = A*x ^ 0xD3.
// Zero has no inverse and is mapped to zero, which the SMS4 S-box requires.

// sms4_inv8: combinational multiplicative inverse in GF(2^8) mod 0x1F5
module sms4_inv8 (
    input  logic [7:0] a,
    output logic [7:0] y
);

    // Field multiply: shift-and-add with reduction by x^8 = 0xF5.
    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] z);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = 8'h00;
        sh  = x;
        for (int i = 0; i < 8; i++) begin
            if (z[i]) acc = acc ^ sh;
            sh = sh[7] ? ({sh[6:0], 1'b0} ^ 8'hF5) : {sh[6:0], 1'b0};
        end
        return acc;
    endfunction

    function automatic logic [7:0] gf_sq(input logic [7:0] x);
        return gf_mul(x, x);
    endfunction

    // a^-1 = a^254, built with an addition chain of squares and multiplies:
    // a^3, a^7, a^15, a^31, a^63, a^127 and finally (a^127)^2.
    // 0^254 = 0, which gives the required inv(0) = 0.
    logic [7:0] p3;
    logic [7:0] p7;
    logic [7:0] p15;
    logic [7:0] p31;
    logic [7:0] p63;
    logic [7:0] p127;

    assign p3   = gf_mul(gf_sq(a), a);
    assign p7   = gf_mul(gf_sq(p3), a);
    assign p15  = gf_mul(gf_sq(p7), a);
    assign p31  = gf_mul(gf_sq(p15), a);
    assign p63  = gf_mul(gf_sq(p31), a);
    assign p127 = gf_mul(gf_sq(p63), a);
    assign y    = gf_sq(p127);

endmodule

// sms4_tau_serial: top level, FSM plus time-shared S-box datapath
module sms4_tau_serial (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_word,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_word,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
`ifdef SBOX_PIPE_EN
        S_DRAIN = 2'd3,
`endif
        S_HOLD  = 2'd2
    } state_t;

    // SMS4 affine step: row i of A has ones at bit positions
    // {i-1, i, i+1, i+2, i+5} mod 8, i.e. mask 0xA7 rotated left by i.
    function automatic logic [7:0] sms4_affine(input logic [7:0] x);
        logic [7:0] row;
        logic [7:0] r;
        row = 8'hA7;
        r   = 8'h00;
        for (int i = 0; i < 8; i++) begin
            r[i] = ^(x & row);
            row  = {row[6:0], row[7]};
        end
        return r ^ 8'hD3;
    endfunction

    // Input map: affine step composed with the (identity) basis change.
    function automatic logic [7:0] map_in(input logic [7:0] x);
        return sms4_affine(x);
    endfunction

    // Output map: (identity) inverse basis change composed with affine step.
    function automatic logic [7:0] map_out(input logic [7:0] x);
        return sms4_affine(x);
    endfunction

    state_t      state;
    logic [1:0]  cnt;
    logic [31:0] src;
    logic [31:0] res;

    logic [1:0]  byte_idx;
    logic [7:0]  sel_byte;
    logic [7:0]  inv_in;
    logic [7:0]  inv_out;

    logic        wr_en;
    logic [1:0]  wr_idx;
    logic [7:0]  wr_byte;

    // MSB first: cnt 0 selects byte 3, cnt 3 selects byte 0.
    assign byte_idx = 2'd3 - cnt;

    // Pick the source byte currently being transformed
    always_comb begin
        // NOTE: a default assignment before the case keeps this purely
        // combinational; a path that leaves sel_byte unassigned infers a latch.
        sel_byte = 8'h00;
        case (byte_idx)
            2'd3:    sel_byte = src[31:24];
            2'd2:    sel_byte = src[23:16];
            2'd1:    sel_byte = src[15:8];
            default: sel_byte = src[7:0];
        endcase
    end

    assign inv_in = map_in(sel_byte);

    sms4_inv8 u_inv8 (
        .a (inv_in),
        .y (inv_out)
    );

`ifdef SBOX_PIPE_EN
    logic [7:0] pipe_q;
    logic [1:0] pipe_idx;
    logic       pipe_vld;

    // Register the inv8 output with its byte index; valid only for RUN issues
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_q   <= 8'h00;
            pipe_idx <= 2'd0;
            pipe_vld <= 1'b0;
        end else begin
            pipe_q   <= inv_out;
            pipe_idx <= byte_idx;
            pipe_vld <= (state == S_RUN);
        end
    end

    assign wr_en   = pipe_vld;
    assign wr_idx  = pipe_idx;
    assign wr_byte = map_out(pipe_q);
`else
    assign wr_en   = (state == S_RUN);
    assign wr_idx  = byte_idx;
    assign wr_byte = map_out(inv_out);
`endif

    // Combinational from state; gated so it reads 0 while reset is held.
    assign in_ready = (state == S_IDLE) && !rst;
    assign out_word = res;

    // Control FSM plus source/result registers and registered status flags
    always_ff @(posedge clk) begin
        // NOTE: every register here uses <= so all updates see the values
        // from before the edge; blocking = would make order-dependent logic.
        if (rst) begin
            // NOTE: the result register is plain flops, not a memory, so it is
            // cleared here along with the rest; a partial result is discarded.
            state     <= S_IDLE;
            cnt       <= 2'd0;
            src       <= 32'h0000_0000;
            res       <= 32'h0000_0000;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            if (wr_en) begin
                res[{wr_idx, 3'b000} +: 8] <= wr_byte;
            end

            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        src   <= in_word;
                        cnt   <= 2'd0;
                        busy  <= 1'b1;
                        state <= S_RUN;
                    end
                end

                S_RUN: begin
                    cnt <= cnt + 2'd1;
                    if (cnt == 2'd3) begin
`ifdef SBOX_PIPE_EN
                        state     <= S_DRAIN;
`else
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= S_HOLD;
`endif
                    end
                end

`ifdef SBOX_PIPE_EN
                S_DRAIN: begin
                    busy      <= 1'b0;
                    out_valid <= 1'b1;
                    state     <= S_HOLD;
                end
`endif

                S_HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end

                default: begin
                    busy      <= 1'b0;
                    out_valid <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/sms4_tau_serial.md
# sms4_tau_serial

Byte-serial SMS4 non-linear transform τ: accepts a 32-bit word and returns the four S-box substitutions packed in the same byte order. It sits directly upstream of the linear transform L in the round function and directly wraps the composite-field `inv8` stage. A single S-box datapath is time-shared across the four bytes:

- input map: SMS4 input affine step composed with the isomorphism into the `inv8` composite field;
- `inv8` instance;
- output map: inverse isomorphism composed with the SMS4 output affine step.

## Interface
Parameters: none.

- `clk`  input  1  single clock; all state updates on rising edge
- `rst`  input  1  reset, synchronous, active-high
- `in_valid`  input  1  `in_word` is offered
- `in_ready`  output  1  block can accept a word (high only in IDLE)
- `in_word`  input  32  τ input, byte 3 = bits [31:24]
- `out_valid`  output  1  `out_word` holds a complete τ result
- `out_ready`  input  1  consumer accepts `out_word`
- `out_word`  output  32  τ result, byte k = S(`in_word` byte k)
- `busy`  output  1  high in RUN and DRAIN

## Operation
- States: IDLE, RUN, DRAIN (only with `SBOX_PIPE_EN`), HOLD. Encoding is free.
- IDLE: `in_ready`=1. On `in_valid` && `in_ready`:
  - latch `in_word` into the source register;
  - set the 2-bit byte counter `cnt` to 0;
  - go to RUN.
- RUN: each cycle, byte index `3-cnt` (MSB first) is selected from the source register and driven through input map → `inv8` → output map. The result is written into the matching byte of the result register. `cnt` increments by 1.
  - Without `SBOX_PIPE_EN`: when `cnt`==3 is written, go to HOLD.
  - With `SBOX_PIPE_EN`: when `cnt`==3 is issued, go to DRAIN.
- DRAIN: writes the last byte, then goes to HOLD.
- HOLD: `out_valid`=1. `out_word` = result register, stable until the handshake. On `out_ready`, go to IDLE; `out_valid` is low the next cycle.
- `out_ready` is ignored outside HOLD. `in_valid` is ignored outside IDLE; no new word is accepted in HOLD, even on the handshake cycle.
- Input and output maps are fixed 8×8 GF(2) matrices plus XOR constants. They are chosen so that the end-to-end byte function equals the SMS4 S-box for all 256 inputs, in the `inv8` field basis. Input 0x00 maps to the composite-field zero, so the inverse of 0 is 0.
- Width rules: `cnt` wraps 3→0, which is only reached on exit from RUN. All datapath is 8-bit GF(2) and has no carries.
- Reset, from any state including mid-RUN or mid-HOLD:
  - next state IDLE;
  - `out_valid`=0, `busy`=0;
  - `out_word`/result register=0x00000000, source register=0, `cnt`=0;
  - any partial result is discarded.
- `in_ready` is combinational from state. It is 0 while `rst` is high and 1 in the first cycle after reset release.

## Timing
- Accept at edge T (`in_valid`&&`in_ready` sampled high).
- Without `SBOX_PIPE_EN`:
  - RUN occupies cycles T+1..T+4;
  - `out_valid` is first high after edge T+4 (latency 4 cycles);
  - minimum word period is 6 cycles with `out_ready` tied high (accept, 4×RUN, HOLD).
- With `SBOX_PIPE_EN`:
  - RUN T+1..T+4, DRAIN T+5;
  - `out_valid` is high after edge T+5 (latency 5 cycles);
  - minimum period is 7 cycles.
- Combinational path per cycle:
  - without the macro: mux + input map + `inv8` + output map;
  - with the macro: split at the `inv8` output register.

## Configuration
- `SBOX_PIPE_EN` defined: an 8-bit register (reset 0x00) sits between the `inv8` output and the output map. A 1-bit valid and 2-bit index travel with it, and the DRAIN state exists.
- Not defined: no pipeline register and no DRAIN state; the byte is written in the same cycle it is selected.
- Function and handshake are identical in both builds; only latency and period differ.

## Test plan
- Reset then `in_word`=0x00000000, `out_ready`=1:
  - `out_word`=0xD6D6D6D6;
  - `out_valid` rises 4 cycles after accept (5 with `SBOX_PIPE_EN`), high for exactly 1 cycle.
- `in_word`=0x00010203 → `out_word`=0xD690E9FE. `in_word`=0xFFFFFFFF → `out_word`=0x48484848.
- Exhaustive: for b in 0..255, `in_word`={b,b,b,b} → each byte equals the SMS4 S-box table entry for b, compared against the golden table.
- Backpressure: `out_ready`=0 for 10 cycles in HOLD:
  - `out_valid` stays 1, `out_word` stays constant, `in_ready` stays 0;
  - `in_valid` pulses in that window are not accepted;
  - raising `out_ready` completes the handshake and returns `in_ready`=1 the next cycle.
- Assert `rst` for 1 cycle at RUN `cnt`==2:
  - next cycle `out_valid`=0, `busy`=0, `out_word`=0x00000000, `in_ready`=1;
  - a subsequent 0x00010203 yields 0xD690E9FE.
- Back-to-back: `in_valid`=1 and `out_ready`=1 held constantly with random words → one result every 6 cycles (7 with `SBOX_PIPE_EN`), all matching the model, none dropped or duplicated.
